controller_multicycle: RTL

//  Multicycle RV32I control FSM; successor to the single-cycle controller.

---
 rtl/controller_multicycle.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/controller_multicycle.sv
// Multicycle RV32I control FSM with memory-ready handshake, stall timeout and sticky fault.
// Define CONTROLLER_BRANCH_EXT_EN to add blt/bge/bltu/bgeu; otherwise those trap as illegal.
module controller_multicycle #(
    parameter bit          MEM_READY_USE  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       IR_write,
    output logic       PC_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] ALU_src_A,
    output logic [1:0] ALU_src_B,
    output logic [2:0] imm_src,
    output logic [3:0] ALU_control,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR,
        S_JALR_LINK, S_U_TYPE, S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    code_q, code_d;

    logic       ready, waiting, br_legal, br_taken;
    logic       mreq, mwr, adr, irw, pcw, rw;
    logic [1:0] rsrc, src_a, src_b;
    logic [2:0] imm;
    logic [3:0] alu, alu_fn;

    assign ready = MEM_READY_USE ? mem_ready : 1'b1;

    always_comb begin
        unique case (funct3)
            3'b000:  alu_fn = (opcode[5] & funct7b5) ? 4'd1 : 4'd0;
            3'b001:  alu_fn = 4'd7;
            3'b010:  alu_fn = 4'd5;
            3'b011:  alu_fn = 4'd6;
            3'b100:  alu_fn = 4'd4;
            3'b101:  alu_fn = funct7b5 ? 4'd9 : 4'd8;
            3'b110:  alu_fn = 4'd3;
            default: alu_fn = 4'd2;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
`ifdef CONTROLLER_BRANCH_EXT_EN
            3'b100:  br_taken = lt;
            3'b101:  br_taken = ~lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = ~ltu;
`endif
            default: br_taken = 1'b0;
        endcase
    end

`ifdef CONTROLLER_BRANCH_EXT_EN
    assign br_legal = (funct3[2:1] != 2'b01);
`else
    assign br_legal = (funct3[2:1] == 2'b00);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        waiting = 1'b0;
        mreq    = 1'b0;
        mwr     = 1'b0;
        adr     = 1'b0;
        irw     = 1'b0;
        pcw     = 1'b0;
        rw      = 1'b0;
        rsrc    = 2'b00;
        src_a   = 2'b00;
        src_b   = 2'b00;
        imm     = 3'b000;
        alu     = 4'd0;
        unique case (state_q)
            S_FETCH: begin
                mreq = 1'b1;
                if (ready) begin
                    irw     = 1'b1;
                    pcw     = 1'b1;
                    src_b   = 2'b10;
                    rsrc    = 2'b10;
                    state_d = S_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                imm   = 3'b010;
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = S_MEM_ADR;
                    7'b0110011:             state_d = S_EXEC_R;
                    7'b0010011:             state_d = S_EXEC_I;
                    7'b1100011: begin
                        state_d = br_legal ? S_BRANCH : S_FAULT;
                        if (!br_legal) code_d = 2'b01;
                    end
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    7'b0110111, 7'b0010111: state_d = S_U_TYPE;
                    default: begin
                        state_d = S_FAULT;
                        code_d  = 2'b01;
                    end
                endcase
            end
            S_MEM_ADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                imm     = opcode[5] ? 3'b001 : 3'b000;
                state_d = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mreq = 1'b1;
                adr  = 1'b1;
                if (ready) state_d = S_MEM_WB;
                else       waiting = 1'b1;
            end
            S_MEM_WB: begin
                rsrc    = 2'b01;
                rw      = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WRITE: begin
                mreq = 1'b1;
                mwr  = 1'b1;
                adr  = 1'b1;
                if (ready) state_d = S_FETCH;
                else       waiting = 1'b1;
            end
            S_EXEC_R: begin
                src_a   = 2'b10;
                alu     = alu_fn;
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu     = alu_fn;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                rw      = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                src_a   = 2'b10;
                alu     = 4'd1;
                pcw     = br_taken;
                state_d = S_FETCH;
            end
            S_JAL: begin
                src_a   = 2'b01;
                src_b   = 2'b10;
                pcw     = 1'b1;
                state_d = S_ALU_WB;
            end
            S_JALR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                rsrc    = 2'b10;
                pcw     = 1'b1;
                state_d = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                src_a   = 2'b01;
                src_b   = 2'b10;
                state_d = S_ALU_WB;
            end
            S_U_TYPE: begin
                src_a   = opcode[5] ? 2'b11 : 2'b01;
                src_b   = 2'b01;
                imm     = 3'b100;
                state_d = S_ALU_WB;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
        // A completing access in the deadline cycle beats the timeout
        if (waiting && MEM_READY_USE) begin
            if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                state_d = S_FAULT;
                code_d  = 2'b10;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign mem_req     = ~reset & mreq;
    assign mem_write   = ~reset & mwr;
    assign adr_src     = ~reset & adr;
    assign IR_write    = ~reset & irw;
    assign PC_write    = ~reset & pcw;
    assign reg_write   = ~reset & rw;
    assign result_src  = reset ? 2'b00 : rsrc;
    assign ALU_src_A   = reset ? 2'b00 : src_a;
    assign ALU_src_B   = reset ? 2'b00 : src_b;
    assign imm_src     = reset ? 3'b000 : imm;
    assign ALU_control = reset ? 4'd0 : alu;
    assign fault       = ~reset & (state_q == S_FAULT);
    assign fault_code  = (reset || state_q != S_FAULT) ? 2'b00 : code_q;
endmodule
